// File: rtl/z80_bus_writer_pkg.sv
// Shared types and constants for the Z80 memory-write bus master.
package z80_bus_writer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TW,
    T3
  } state_t;

  localparam logic STROBE_OFF = 1'b1;

  // Phase counter width; a divide of 1 still needs a 1-bit counter.
  function automatic int cnt_width(input int half_div);
    return (half_div > 1) ? $clog2(half_div) : 1;
  endfunction

endpackage

// File: rtl/z80_bus_writer_fifo.sv
// Request FIFO: first-word-fall-through, simultaneous push/pop, occupancy counter.
module z80_bus_writer_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; the occupancy counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/z80_bus_writer.sv
// Z80-style bus master replaying queued requests as 3-T-state memory writes.
// Define Z80_BUS_WRITER_WAIT_EN to add the active-low WAIT input and the TW state.
module z80_bus_writer
  import z80_bus_writer_pkg::*;
#(
  parameter int HALF_DIV   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_DATA,
`ifdef Z80_BUS_WRITER_WAIT_EN
  input  logic              WAIT,
`endif
  output logic              Z80_CLK,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  output logic              D_OE,
  output logic              MRQ,
  output logic              WR,
  output logic              RD,
  output logic              IORQ,
  output logic              M1,
  output logic              BUSY,
  output logic              DONE
);

  localparam int CNT_W = cnt_width(HALF_DIV);
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [CNT_W-1:0]  phase;
  logic              tick;
  logic              rise;
  logic              fall;
  logic              ready_en;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [ENT_W-1:0]  head;
  logic [DATA_W-1:0] data_q;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] a_nxt;
  logic [DATA_W-1:0] d_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              doe_nxt;
  logic              mrq_nxt;
  logic              wr_nxt;
  logic              done_nxt;

  // ---------------- bus clock divider ----------------
  assign tick = (phase == CNT_W'(HALF_DIV - 1));
  assign rise = tick && !Z80_CLK;
  assign fall = tick && Z80_CLK;

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      phase   <= '0;
      Z80_CLK <= 1'b0;
    end else if (tick) begin
      phase   <= '0;
      Z80_CLK <= ~Z80_CLK;
    end else begin
      phase   <= phase + CNT_W'(1);
    end
  end

  // ---------------- request FIFO ----------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  assign REQ_READY = ready_en && !fifo_full;
  assign BUSY      = (state != IDLE) || !fifo_empty;

  z80_bus_writer_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (REQ_VALID && REQ_READY),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .din   ({REQ_ADDR, REQ_DATA}),
    .dout  (head)
  );

  // ---------------- optional WAIT synchronizer ----------------
`ifdef Z80_BUS_WRITER_WAIT_EN
  logic wait_s1;
  logic wait_s2;
  logic wait_smp;
  logic wait_smp_nxt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_s1  <= 1'b1;
      wait_s2  <= 1'b1;
      wait_smp <= 1'b1;
    end else begin
      wait_s1  <= WAIT;
      wait_s2  <= wait_s1;
      wait_smp <= wait_smp_nxt;
    end
  end
`endif

  // ---------------- T-state sequencer ----------------
  // NOTE: every signal gets its default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    a_nxt     = A;
    d_nxt     = D;
    data_nxt  = data_q;
    doe_nxt   = D_OE;
    mrq_nxt   = MRQ;
    wr_nxt    = WR;
    done_nxt  = 1'b0;
`ifdef Z80_BUS_WRITER_WAIT_EN
    wait_smp_nxt = wait_smp;
`endif
    case (state)
      IDLE: begin
        if (rise && !fifo_empty) begin
          pop       = 1'b1;
          a_nxt     = head[DATA_W +: ADDR_W];
          data_nxt  = head[DATA_W-1:0];
          state_nxt = T1;
        end
      end
      T1: begin
        if (fall) begin
          mrq_nxt = 1'b0;
          d_nxt   = data_q;
          doe_nxt = 1'b1;
        end else if (rise) begin
          state_nxt = T2;
        end
      end
      T2: begin
        if (fall) begin
          wr_nxt = 1'b0;
`ifdef Z80_BUS_WRITER_WAIT_EN
          wait_smp_nxt = wait_s2;
`endif
        end else if (rise) begin
`ifdef Z80_BUS_WRITER_WAIT_EN
          state_nxt = wait_smp ? T3 : TW;
`else
          state_nxt = T3;
`endif
        end
      end
`ifdef Z80_BUS_WRITER_WAIT_EN
      TW: begin
        if (fall)                  wait_smp_nxt = wait_s2;
        else if (rise && wait_smp) state_nxt    = T3;
      end
`endif
      T3: begin
        if (fall) begin
          mrq_nxt = STROBE_OFF;
          wr_nxt  = STROBE_OFF;
        end else if (rise) begin
          doe_nxt  = 1'b0;
          done_nxt = 1'b1;
          // Back-to-back: the next request starts T1 on this very rise.
          if (!fifo_empty) begin
            pop       = 1'b1;
            a_nxt     = head[DATA_W +: ADDR_W];
            data_nxt  = head[DATA_W-1:0];
            state_nxt = T1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      A      <= '0;
      D      <= '0;
      data_q <= '0;
      D_OE   <= 1'b0;
      MRQ    <= STROBE_OFF;
      WR     <= STROBE_OFF;
      RD     <= STROBE_OFF;
      IORQ   <= STROBE_OFF;
      M1     <= STROBE_OFF;
      DONE   <= 1'b0;
    end else begin
      state  <= state_nxt;
      A      <= a_nxt;
      D      <= d_nxt;
      data_q <= data_nxt;
      D_OE   <= doe_nxt;
      MRQ    <= mrq_nxt;
      WR     <= wr_nxt;
      RD     <= STROBE_OFF;
      IORQ   <= STROBE_OFF;
      M1     <= STROBE_OFF;
      DONE   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_z80_bus_writer.sv
// Scoreboard bench: pushes random writes, a bus snooper checks address/data order and strobe timing.
module tb_z80_bus_writer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [15:0] REQ_ADDR = '0;
  logic [7:0]  REQ_DATA = '0;
  logic        Z80_CLK;
  logic [15:0] A;
  logic [7:0]  D;
  logic        D_OE, MRQ, WR, RD, IORQ, M1, BUSY, DONE;
`ifdef Z80_BUS_WRITER_WAIT_EN
  logic        wait_n = 1'b1;
`endif

  always #5 CLK = ~CLK;

  z80_bus_writer #(
    .HALF_DIV   (2),
    .FIFO_DEPTH (4),
    .ADDR_W     (16),
    .DATA_W     (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_DATA  (REQ_DATA),
`ifdef Z80_BUS_WRITER_WAIT_EN
    .WAIT      (wait_n),
`endif
    .Z80_CLK   (Z80_CLK),
    .A         (A),
    .D         (D),
    .D_OE      (D_OE),
    .MRQ       (MRQ),
    .WR        (WR),
    .RD        (RD),
    .IORQ      (IORQ),
    .M1        (M1),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  n_obs = 0;
  int  n_done = 0;
  int  last_done_cyc = -100;
  int  done_gap = 0;
  int  acc_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- snooper / scoreboard monitor ----------------
  logic prev_z = 1'b0, prev_mrq = 1'b1, prev_wr = 1'b1, prev_done = 1'b0;
  logic captured = 1'b0;
  int   mrq_fall_cyc = 0;

  always @(negedge CLK) begin
    logic z_rise, z_fall;
    wr_t  e;
    if (!RST) begin
      prev_z = 1'b0; prev_mrq = 1'b1; prev_wr = 1'b1; prev_done = 1'b0; captured = 1'b0;
    end else begin
      z_rise = Z80_CLK && !prev_z;
      z_fall = !Z80_CLK && prev_z;
      if (prev_mrq && !MRQ) begin
        check("mrq_fall_on_t1_fall", z_fall, 1'b1);
        check("doe_with_mrq_fall", D_OE, 1'b1);
        mrq_fall_cyc = cyc;
      end
      if (prev_wr && !WR) begin
        check("wr_fall_on_t2_fall", z_fall, 1'b1);
        check("wr_fall_delay", cyc - mrq_fall_cyc, 4);
      end
      if (!prev_mrq && MRQ) begin
        check("mrq_rise_on_t3_fall", z_fall, 1'b1);
        check("mrq_low_width", cyc - mrq_fall_cyc, 8);
        check("wr_rise_with_mrq", WR, 1'b1);
        captured = 1'b0;
      end
      if (z_rise && !MRQ && !WR && !captured) begin
        captured = 1'b1;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got A=%h D=%h, required no bus write", A, D);
        end else begin
          e = exp_q.pop_front();
          check("bus_addr", A, e.a);
          check("bus_data", D, e.d);
          check("doe_at_t3_start", D_OE, 1'b1);
          n_obs++;
        end
      end
      if (DONE) begin
        check("done_one_clk", prev_done, 1'b0);
        check("done_on_rise", z_rise, 1'b1);
        check("done_after_mrq", cyc - mrq_fall_cyc, 10);
        check("doe_off_at_done", D_OE, 1'b0);
        check("busy_at_done", BUSY, exp_q.size() != 0);
        done_gap      = cyc - last_done_cyc;
        last_done_cyc = cyc;
        n_done++;
      end
      prev_z = Z80_CLK; prev_mrq = MRQ; prev_wr = WR; prev_done = DONE;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_req(input logic [15:0] a, input logic [7:0] d, output int waits);
    wr_t e;
    waits     = 0;
    REQ_VALID = 1'b1;
    REQ_ADDR  = a;
    REQ_DATA  = d;
    forever begin
      @(negedge CLK);
      if (REQ_READY) begin
        acc_cyc = cyc;
        @(posedge CLK);
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
        #1;
        break;
      end
      waits++;
      if (waits > 300) begin
        n_vec++;
        n_err++;
        $display("FAIL push_timeout: got no REQ_READY in %0d cycles, required acceptance", waits);
        break;
      end
    end
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int i;
    for (i = 0; i < 600 && n_done < target; i++) begin
      @(posedge CLK);
      #1;
    end
    check(name, n_done, target);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int w, base, k, obs_snap, done_snap, i;
    int t_rise[2];
    logic p;

    idle(3);
    check("rst_z80_clk", Z80_CLK, 1'b0);
    check("rst_a", A, 16'h0000);
    check("rst_d", D, 8'h00);
    check("rst_d_oe", D_OE, 1'b0);
    check("rst_strobes", {MRQ, WR, RD, IORQ, M1}, 5'b11111);
    check("rst_busy_done", {BUSY, DONE}, 2'b00);
    check("rst_req_ready", REQ_READY, 1'b0);

    RST = 1'b1;
    idle(1);
    check("ready_after_reset", REQ_READY, 1'b1);
    check("idle_strobes", {MRQ, WR}, 2'b11);
    check("idle_addr", A, 16'h0000);

    k = 0;
    p = Z80_CLK;
    for (i = 0; i < 40 && k < 2; i++) begin
      @(posedge CLK);
      #1;
      if (Z80_CLK && !p) begin
        t_rise[k] = cyc;
        k++;
      end
      p = Z80_CLK;
    end
    check("z80_clk_rises_seen", k, 2);
    if (k == 2) check("z80_clk_period", t_rise[1] - t_rise[0], 4);

    // single write
    base = n_done;
    push_req(16'h4000, 8'hA5, w);
    wait_done(base + 1, "single_done");
    check("single_busy_after", BUSY, 1'b0);
    check("single_addr_held", A, 16'h4000);
    idle(8);
    check("single_one_done", n_done, base + 1);
    check("single_d_held", D, 8'hA5);

    // back-to-back
    base = n_done;
    push_req(16'h5AFF, 8'h01, w);
    push_req(16'h5800, 8'h47, w);
    wait_done(base + 2, "b2b_done");
    check("b2b_done_gap", done_gap, 12);
    idle(4);

    // FIFO full while a write is in flight
    base = n_done;
    push_req(16'h1234, 8'h56, w);
    for (i = 0; i < 40 && MRQ; i++) idle(1);
    check("full_dummy_started", MRQ, 1'b0);
    for (int j = 0; j < 4; j++) begin
      push_req(16'h4100 + 16'(j), 8'h10 + 8'(j), w);
      check("full_accept_no_wait", w, 0);
    end
    check("ready_low_when_full", REQ_READY, 1'b0);
    push_req(16'h4104, 8'h14, w);
    check("fifth_waited", w > 0, 1'b1);
    check("ready_back_at_first_pop", acc_cyc, last_done_cyc);
    wait_done(base + 6, "full_all_done");
    check("full_queue_drained", exp_q.size(), 0);

    // randomized traffic
    base = n_done;
    for (int j = 0; j < 24; j++) begin
      idle($urandom_range(0, 14));
      push_req(16'($urandom), 8'($urandom), w);
    end
    wait_done(base + 24, "random_all_done");
    check("random_queue_drained", exp_q.size(), 0);
    check("random_idle_busy", BUSY, 1'b0);

    // reset in the middle of T2
    push_req(16'h4A00, 8'hC3, w);
    push_req(16'h4A01, 8'hC4, w);
    push_req(16'h4A02, 8'hC5, w);
    for (i = 0; i < 60 && WR; i++) idle(1);
    check("reset_test_in_t2", WR, 1'b0);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("midrst_strobes", {MRQ, WR, RD, IORQ, M1}, 5'b11111);
    check("midrst_bus", {Z80_CLK, D_OE, A, D}, 26'h0);
    check("midrst_flags", {BUSY, DONE, REQ_READY}, 3'b000);
    exp_q.delete();
    obs_snap  = n_obs;
    done_snap = n_done;
    idle(3);
    RST = 1'b1;
    idle(80);
    check("midrst_no_replay_obs", n_obs, obs_snap);
    check("midrst_no_replay_done", n_done, done_snap);
    check("midrst_idle_after", {BUSY, MRQ, WR}, 3'b011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
